// File: rtl/mips_pkg.sv
// Shared constants and the fetch FSM encoding for the MIPS front end.
package mips_pkg;

  localparam int NB_PC_DEF    = 32;
  localparam int NB_INSTR_DEF = 32;
  localparam int PC_STEP      = 4;

  // All-ones word stops the fetch stream; all-zeros is the bubble NOP.
  localparam logic [NB_INSTR_DEF-1:0] HALT_INSTR = {NB_INSTR_DEF{1'b1}};
  localparam logic [NB_INSTR_DEF-1:0] NOP_INSTR  = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: hold beats bubble, bubble beats load.
module if_id_latch
  import mips_pkg::*;
#(
  parameter int NB_PC    = NB_PC_DEF,
  parameter int NB_INSTR = NB_INSTR_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_hold,
  input  logic                i_bubble,
  input  logic [NB_INSTR-1:0] i_instr,
  input  logic [NB_PC-1:0]    i_pc_plus4,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc_plus4,
  output logic                o_valid
);

  logic [NB_INSTR-1:0] r_instr;
  logic [NB_PC-1:0]    r_pc_plus4;
  logic                r_valid;

  // Bubble keeps the old pc_plus4; only the instruction and valid are squashed.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_hold) begin
      r_instr    <= r_instr;
      r_pc_plus4 <= r_pc_plus4;
      r_valid    <= r_valid;
    end else if (i_bubble) begin
      r_instr    <= NB_INSTR'(NOP_INSTR);
      r_valid    <= 1'b0;
    end else begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, run/halt FSM, saturating fetch counter, IF/ID latch.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int NB_PC    = NB_PC_DEF,
  parameter int NB_INSTR = NB_INSTR_DEF,
  parameter int NB_CNT   = 32
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [NB_PC-1:0]    i_redirect_pc,
  output logic [NB_PC-1:0]    o_imem_addr,
  input  logic [NB_INSTR-1:0] i_imem_data,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc_plus4,
  output logic                o_valid,
  output logic                o_halted,
  output logic [NB_CNT-1:0]   o_fetch_count
);

  fetch_state_e      r_state, w_state_nxt;
  logic [NB_PC-1:0]  r_pc, w_pc_nxt, w_pc_plus4;
  logic [NB_CNT-1:0] r_cnt;
  logic              w_hold, w_bubble, w_accept, w_is_halt;

  assign w_pc_plus4 = r_pc + NB_PC'(PC_STEP);
  assign w_is_halt  = (i_imem_data == NB_INSTR'(HALT_INSTR));

  // Next state and IF/ID controls; default is "hold everything".
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold      = 1'b1;
    w_bubble    = 1'b0;
    w_accept    = 1'b0;
    if (i_enable) begin
      case (r_state)
        ST_RUN: begin
          if (i_stall) begin
            w_hold = 1'b1;
          end else if (i_redirect) begin
            w_hold   = 1'b0;
            w_bubble = 1'b1;
            w_pc_nxt = {i_redirect_pc[NB_PC-1:2], 2'b00};
          end else begin
            w_hold   = 1'b0;
            w_accept = 1'b1;
            w_pc_nxt = w_pc_plus4;
            if (w_is_halt) w_state_nxt = ST_HALTED;
          end
        end
        ST_HALTED: begin
          w_hold   = 1'b0;
          w_bubble = 1'b1;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // State, PC and counter registers; counter sticks at all ones.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_RUN;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_accept && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end

  if_id_latch #(
    .NB_PC    (NB_PC),
    .NB_INSTR (NB_INSTR)
  ) u_if_id (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_hold     (w_hold),
    .i_bubble   (w_bubble),
    .i_instr    (i_imem_data),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (o_instr),
    .o_pc_plus4 (o_pc_plus4),
    .o_valid    (o_valid)
  );

  assign o_imem_addr   = r_pc;
  assign o_halted      = (r_state == ST_HALTED);
  assign o_fetch_count = r_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a narrow counter makes saturation reachable.
module tb_fetch_stage;

  localparam int NB_CNT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en, stall, redir;
  logic [31:0]       redir_pc;
  logic [31:0]       imem_addr, imem_data, instr, pc4;
  logic              valid, halted;
  logic [NB_CNT-1:0] cnt;
  logic              halt_en;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  // Memory image: word = 0x20080001 + address, halt word at 0x40 when armed.
  assign imem_data = (halt_en && imem_addr == 32'h40) ? 32'hFFFF_FFFF
                                                      : 32'h2008_0001 + imem_addr;

  fetch_stage #(.NB_PC(32), .NB_INSTR(32), .NB_CNT(NB_CNT)) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_enable      (en),
    .i_stall       (stall),
    .i_redirect    (redir),
    .i_redirect_pc (redir_pc),
    .o_imem_addr   (imem_addr),
    .i_imem_data   (imem_data),
    .o_instr       (instr),
    .o_pc_plus4    (pc4),
    .o_valid       (valid),
    .o_halted      (halted),
    .o_fetch_count (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] a, input logic [31:0] i,
                           input logic [31:0] p, input logic v, input logic [31:0] c);
    chk({tag, ".addr"},  imem_addr, a);
    chk({tag, ".instr"}, instr, i);
    chk({tag, ".pc4"},   pc4, p);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".cnt"},   32'(cnt), c);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = '0; halt_en = 1'b1;
    #12;
    chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("reset.halted", 32'(halted), 32'd0);

    @(negedge clk); rst_n = 1'b1; en = 1'b1;
    step(); chk_state("first", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 32'd1);
    step(); chk_state("f2", 32'h8, 32'h2008_0005, 32'h8, 1'b1, 32'd2);
    step(); step();
    chk_state("f4", 32'h10, 32'h2008_000D, 32'h10, 1'b1, 32'd4);

    // Stall three cycles at 0x10
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_state("stall", 32'h10, 32'h2008_000D, 32'h10, 1'b1, 32'd4);
    end
    stall = 1'b0;
    step(); chk_state("resume", 32'h14, 32'h2008_0011, 32'h14, 1'b1, 32'd5);

    // Enable low freezes everything
    en = 1'b0;
    step(); chk_state("disable", 32'h14, 32'h2008_0011, 32'h14, 1'b1, 32'd5);
    en = 1'b1;
    step(); step(); step();
    chk_state("to20", 32'h20, 32'h2008_001D, 32'h20, 1'b1, 32'd8);

    // Redirect with misaligned target
    redir = 1'b1; redir_pc = 32'h103;
    step();
    chk("redir.addr",  imem_addr, 32'h100);
    chk("redir.valid", 32'(valid), 32'd0);
    chk("redir.instr", instr, 32'h0);
    chk("redir.cnt",   32'(cnt), 32'd8);

    // Stall beats redirect at 0x30
    redir_pc = 32'h30;
    step(); chk("redir30.addr", imem_addr, 32'h30);
    stall = 1'b1; redir_pc = 32'h200;
    step();
    chk("stallredir.addr", imem_addr, 32'h30);
    chk("stallredir.cnt",  32'(cnt), 32'd8);
    stall = 1'b0;
    step();
    chk("redir200.addr",  imem_addr, 32'h200);
    chk("redir200.valid", 32'(valid), 32'd0);

    // Halt word at 0x40: not accepted while stalled, then accepted
    redir_pc = 32'h40;
    step(); redir = 1'b0; chk("at40.addr", imem_addr, 32'h40);
    stall = 1'b1;
    step();
    chk("halt_stalled.halted", 32'(halted), 32'd0);
    chk("halt_stalled.addr", imem_addr, 32'h40);
    stall = 1'b0;
    step();
    chk_state("halt", 32'h44, 32'hFFFF_FFFF, 32'h44, 1'b1, 32'd9);
    chk("halt.halted", 32'(halted), 32'd1);
    redir = 1'b1; redir_pc = 32'h80;
    step();
    chk("halted.addr",   imem_addr, 32'h44);
    chk("halted.valid",  32'(valid), 32'd0);
    chk("halted.instr",  instr, 32'h0);
    chk("halted.cnt",    32'(cnt), 32'd9);
    chk("halted.halted", 32'(halted), 32'd1);
    step();
    chk("halted2.addr", imem_addr, 32'h44);
    redir = 1'b0;

    // Asynchronous reset while halted
    #2 rst_n = 1'b0; halt_en = 1'b0;
    #1;
    chk_state("areset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("areset.halted", 32'(halted), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step(); chk_state("refetch", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 32'd1);

    // PC wrap from 0xFFFFFFFC
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    step(); redir = 1'b0;
    chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk_state("wrap", 32'h0, 32'h2007_FFFD, 32'h0, 1'b1, 32'd2);

    // Counter saturation (4-bit)
    for (int k = 0; k < 13; k++) step();
    chk("sat.cnt15", 32'(cnt), 32'd15);
    step(); step();
    chk("sat.hold", 32'(cnt), 32'd15);
    chk("sat.addr", imem_addr, 32'h3C);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
